// File: rtl/cc_uart_pkg.sv
// Shared types and constants for the uart_tx scheduler slice.
// UART_SCHED_HDR_EN adds the HDR state used for per-packet source headers.
package cc_uart_pkg;

    localparam logic [3:0] HDR_TAG        = 4'hA;
    localparam int         UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE
`ifdef UART_SCHED_HDR_EN
        , S_HDR
`endif
    } sched_state_e;

    function automatic logic [UART_DATA_BITS-1:0] hdr_byte(input logic [2:0] id);
        return {HDR_TAG, 1'b0, id};
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte streams plus the uart_tx start/busy handshake.
// master = scheduler side, slave = requesters and transmitter side.
interface uart_tx_sched_if
    import cc_uart_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [UART_DATA_BITS*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]                req_last;
    logic [NUM_REQ-1:0]                req_ready;
    logic                              tx_start;
    logic [UART_DATA_BITS-1:0]         tx_data;
    logic                              tx_busy;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after i_rr_ptr, wrapping.
module rr_arbiter
    import cc_uart_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_found
);
    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        // k is the distance past the pointer, so the pointer itself is searched last
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!o_found && i_req[j] && (j == ((int'(i_rr_ptr) + k) % NUM_REQ))) begin
                    o_grant[j] = 1'b1;
                    o_found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one uart_tx; IDLE->ARB->[HDR]->LOAD->WAIT_BUSY->WAIT_DONE.
// Build option UART_SCHED_HDR_EN sends a {A,0,id} header byte ahead of every packet.
module uart_tx_sched
    import cc_uart_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  MAX_PKT_LEN = 16,
    parameter int  CNT_W       = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_sched_if.master  bus,
    output logic [ID_W-1:0]  grant_id,
    output logic             pkt_active,
    output logic [CNT_W-1:0] pkt_count
);
    localparam int BC_W = $clog2(MAX_PKT_LEN + 1);

    sched_state_e              r_state, w_state_nxt;
    logic [ID_W-1:0]           r_rr_ptr, w_rr_ptr_nxt;
    logic [ID_W-1:0]           r_grant_id, w_grant_id_nxt;
    logic                      r_pkt_active, w_pkt_active_nxt;
    logic [CNT_W-1:0]          r_pkt_count, w_pkt_count_nxt;
    logic [BC_W-1:0]           r_byte_cnt, w_byte_cnt_nxt;
    logic                      r_last, w_last_nxt;
    logic [NUM_REQ-1:0]        r_req_ready, w_req_ready_nxt;
    logic                      r_tx_start, w_tx_start_nxt;
    logic [UART_DATA_BITS-1:0] r_tx_data, w_tx_data_nxt;
`ifdef UART_SCHED_HDR_EN
    logic                      r_is_hdr, w_is_hdr_nxt;
`endif

    logic [NUM_REQ-1:0]        w_grant;
    logic                      w_found;
    logic [ID_W-1:0]           w_win_id;
    logic [NUM_REQ-1:0]        w_gnt_sel;
    logic [UART_DATA_BITS-1:0] w_gnt_data;
    logic                      w_gnt_last;
    logic                      w_gnt_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req    (bus.req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_found  (w_found)
    );

    always_comb begin
        w_gnt_sel  = '0;
        w_gnt_data = '0;
        w_gnt_last = 1'b0;
        w_win_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_gnt_sel[i] = 1'b1;
                w_gnt_data   = bus.req_data[UART_DATA_BITS*i +: UART_DATA_BITS];
                w_gnt_last   = bus.req_last[i];
            end
            if (w_grant[i]) w_win_id = ID_W'(i);
        end
    end

    assign w_gnt_valid = |(bus.req_valid & w_gnt_sel);

    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_grant_id_nxt   = r_grant_id;
        w_pkt_active_nxt = r_pkt_active;
        w_pkt_count_nxt  = r_pkt_count;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_last_nxt       = r_last;
        w_req_ready_nxt  = '0;
        w_tx_start_nxt   = 1'b0;
        w_tx_data_nxt    = r_tx_data;
`ifdef UART_SCHED_HDR_EN
        w_is_hdr_nxt     = r_is_hdr;
`endif
        case (r_state)
            S_IDLE: begin
                w_pkt_active_nxt = 1'b0;
                if (|bus.req_valid) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (w_found) begin
                    w_grant_id_nxt   = w_win_id;
                    w_pkt_active_nxt = 1'b1;
                    w_byte_cnt_nxt   = '0;
`ifdef UART_SCHED_HDR_EN
                    w_state_nxt      = S_HDR;
`else
                    w_state_nxt      = S_LOAD;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef UART_SCHED_HDR_EN
            S_HDR: begin
                if (!bus.tx_busy) begin
                    w_tx_data_nxt  = hdr_byte(3'(r_grant_id));
                    w_tx_start_nxt = 1'b1;
                    w_is_hdr_nxt   = 1'b1;
                    w_state_nxt    = S_WAIT_BUSY;
                end
            end
`endif
            S_LOAD: begin
                if (w_gnt_valid && !bus.tx_busy) begin
                    w_tx_data_nxt   = w_gnt_data;
                    w_tx_start_nxt  = 1'b1;
                    w_req_ready_nxt = w_gnt_sel;
                    w_last_nxt      = w_gnt_last;
                    w_byte_cnt_nxt  = r_byte_cnt + BC_W'(1);
                    w_state_nxt     = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
`ifdef UART_SCHED_HDR_EN
                    w_is_hdr_nxt = 1'b0;
                    if (r_is_hdr) w_state_nxt = S_LOAD;
                    else
`endif
                    // a forced release leaves the rest of the packet queued for a fresh arbitration
                    if (r_last || (r_byte_cnt == BC_W'(MAX_PKT_LEN))) begin
                        w_rr_ptr_nxt     = r_grant_id;
                        w_pkt_count_nxt  = r_pkt_count + CNT_W'(1);
                        w_pkt_active_nxt = 1'b0;
                        w_state_nxt      = S_IDLE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= ID_W'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_pkt_active <= 1'b0;
            r_pkt_count  <= '0;
            r_byte_cnt   <= '0;
            r_last       <= 1'b0;
            r_req_ready  <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
`ifdef UART_SCHED_HDR_EN
            r_is_hdr     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_pkt_active <= w_pkt_active_nxt;
            r_pkt_count  <= w_pkt_count_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_last       <= w_last_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_data    <= w_tx_data_nxt;
`ifdef UART_SCHED_HDR_EN
            r_is_hdr     <= w_is_hdr_nxt;
`endif
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_data   = r_tx_data;
    assign grant_id      = r_grant_id;
    assign pkt_active    = r_pkt_active;
    assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: queued requester streams plus a 10-cycle busy transmitter model.
module tb_uart_tx_sched;
    import cc_uart_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int MAX_PKT_LEN = 16;
    localparam int CNT_W       = 16;
    localparam int ID_W        = 2;
    localparam int BUSY_LEN    = 10;
    localparam int BUDGET      = 3000;
`ifdef UART_SCHED_HDR_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [ID_W-1:0]  grant_id;
    logic             pkt_active;
    logic [CNT_W-1:0] pkt_count;

    uart_tx_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_sched #(
        .NUM_REQ     (NUM_REQ),
        .MAX_PKT_LEN (MAX_PKT_LEN),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .grant_id   (grant_id),
        .pkt_active (pkt_active),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    // rq entries are {last, data}; scoreboard entries are {grant_id, byte}
    logic [8:0] rq [NUM_REQ][$];
    logic [9:0] obs_q [$];
    logic [9:0] exp_q [$];
    int ready_cnt [NUM_REQ];
    int ready_err = 0;
    int busy_cnt  = 0;
    int n_tests   = 0;
    int n_fail    = 0;

    always @(negedge clk) begin
        logic [8:0] head;
        if (!rst_n) begin
            ready_err = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rq[i].delete();
                ready_cnt[i] = 0;
            end
        end else begin
            if ($countones(bus.req_ready) > 1 ||
                (bus.req_ready & ~(NUM_REQ'(1) << grant_id)) != '0)
                ready_err++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i]) begin
                    ready_cnt[i]++;
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() > 0) begin
                head = rq[i][0];
                bus.req_valid[i]      = 1'b1;
                bus.req_data[8*i +: 8] = head[7:0];
                bus.req_last[i]       = head[8];
            end else begin
                bus.req_valid[i]      = 1'b0;
                bus.req_data[8*i +: 8] = 8'h00;
                bus.req_last[i]       = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            obs_q.push_back({grant_id, bus.tx_data});
            busy_cnt = BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        bus.tx_busy = (busy_cnt != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic exp_hdr(input int src);
`ifdef UART_SCHED_HDR_EN
        exp_q.push_back({ID_W'(src), HDR_TAG, 1'b0, 3'(src)});
`endif
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int c = 0;
        while (obs_q.size() < n && c < BUDGET) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (BUSY_LEN + 4) @(posedge clk);
        #1;
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %b required 0", bus.tx_start); end
        n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h required 00", bus.tx_data); end
        n_tests++; if (bus.req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready got %b required 0000", bus.req_ready); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got %0d required 0", grant_id); end
        n_tests++; if (pkt_active !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_active got %b required 0", pkt_active); end
        n_tests++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count got %0d required 0", pkt_count); end
    endtask

    task automatic test_single();
        bit ok;
        logic [9:0] e, o;
        apply_reset();
        rq[0].push_back({1'b0, 8'h11});
        rq[0].push_back({1'b0, 8'h22});
        rq[0].push_back({1'b1, 8'h33});
        exp_hdr(0);
        exp_q.push_back({2'd0, 8'h11});
        exp_q.push_back({2'd0, 8'h22});
        exp_q.push_back({2'd0, 8'h33});
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.tx_start !== 1'b0 || pkt_active !== 1'b1) begin n_fail++; $display("FAIL single_early got start=%b active=%b required start=0 active=1", bus.tx_start, pkt_active); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.tx_start !== 1'b1) begin n_fail++; $display("FAIL single_latency got tx_start=%b required 1 three cycles after valid", bus.tx_start); end
        wait_obs(exp_q.size(), ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_wait got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL single_byte got nothing required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL single_byte got %h required %h", o, e); end end
        end
        n_tests++; if (ready_cnt[0] !== 3) begin n_fail++; $display("FAIL single_ready got %0d required 3", ready_cnt[0]); end
        n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d required 1", pkt_count); end
        n_tests++; if (ready_err !== 0) begin n_fail++; $display("FAIL single_ready_proto got %0d required 0", ready_err); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [9:0] e, o;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            rq[i].push_back({1'b1, 8'h40 + 8'(i)});
            rq[i].push_back({1'b1, 8'h50 + 8'(i)});
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                exp_hdr(i);
                exp_q.push_back({ID_W'(i), 8'h40 + 8'(16*r) + 8'(i)});
            end
        end
        wait_obs(exp_q.size(), ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_wait got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL rr_order got nothing required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL rr_order got %h required %h", o, e); end end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_tests++; if (ready_cnt[i] !== 2) begin n_fail++; $display("FAIL rr_ready%0d got %0d required 2", i, ready_cnt[i]); end
        end
        n_tests++; if (pkt_count !== 16'd8) begin n_fail++; $display("FAIL rr_count got %0d required 8", pkt_count); end
        n_tests++; if (ready_err !== 0) begin n_fail++; $display("FAIL rr_ready_proto got %0d required 0", ready_err); end
    endtask

    task automatic test_force_release();
        bit ok;
        logic [9:0] e, o;
        apply_reset();
        for (int k = 0; k < 20; k++) rq[1].push_back({(k == 19), 8'h80 + 8'(k)});
        for (int k = 0; k < 3; k++)  rq[2].push_back({(k == 2), 8'hC0 + 8'(k)});
        exp_hdr(1);
        for (int k = 0; k < MAX_PKT_LEN; k++) exp_q.push_back({2'd1, 8'h80 + 8'(k)});
        exp_hdr(2);
        for (int k = 0; k < 3; k++) exp_q.push_back({2'd2, 8'hC0 + 8'(k)});
        exp_hdr(1);
        for (int k = MAX_PKT_LEN; k < 20; k++) exp_q.push_back({2'd1, 8'h80 + 8'(k)});
        wait_obs(exp_q.size(), ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL force_wait got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL force_order got nothing required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL force_order got %h required %h", o, e); end end
        end
        n_tests++; if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL force_count got %0d required 3", pkt_count); end
        n_tests++; if (ready_cnt[1] !== 20) begin n_fail++; $display("FAIL force_ready1 got %0d required 20", ready_cnt[1]); end
    endtask

    task automatic test_stall();
        bit ok;
        bit moved = 1'b0;
        logic [9:0] e, o;
        apply_reset();
        rq[0].push_back({1'b0, 8'h01});
        rq[0].push_back({1'b0, 8'h02});
        rq[1].push_back({1'b1, 8'hA1});
        exp_hdr(0);
        exp_q.push_back({2'd0, 8'h01});
        exp_q.push_back({2'd0, 8'h02});
        wait_obs(exp_q.size(), ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_wait got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL stall_pre got nothing required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL stall_pre got %h required %h", o, e); end end
        end
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (grant_id !== 2'd0 || pkt_active !== 1'b1) moved = 1'b1;
        end
        n_tests++; if (moved) begin n_fail++; $display("FAIL stall_grant got grant moved required grant 0 held"); end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL stall_tx got %0d starts required 0", obs_q.size()); end
        rq[0].push_back({1'b0, 8'h03});
        rq[0].push_back({1'b1, 8'h04});
        exp_q.push_back({2'd0, 8'h03});
        exp_q.push_back({2'd0, 8'h04});
        exp_hdr(1);
        exp_q.push_back({2'd1, 8'hA1});
        wait_obs(exp_q.size(), ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_resume got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL stall_post got nothing required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL stall_post got %h required %h", o, e); end end
        end
        n_tests++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL stall_count got %0d required 2", pkt_count); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c = 0;
        logic [9:0] e, o;
        apply_reset();
        rq[1].push_back({1'b1, 8'h71});
        exp_hdr(1);
        exp_q.push_back({2'd1, 8'h71});
        wait_obs(exp_q.size(), ok);
        obs_q.delete();
        exp_q.delete();
        n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL rstmid_pre_count got %0d required 1", pkt_count); end
        rq[0].push_back({1'b0, 8'h61});
        rq[0].push_back({1'b1, 8'h62});
        while (obs_q.size() < HDR_N + 1 && c < BUDGET) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (pkt_active !== 1'b1 || bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_active got active=%b busy=%b required 1 1", pkt_active, bus.tx_busy); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_start got %b required 0", bus.tx_start); end
        n_tests++; if (pkt_active !== 1'b0) begin n_fail++; $display("FAIL rstmid_pkt_active got %b required 0", pkt_active); end
        n_tests++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_pkt_count got %0d required 0", pkt_count); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_grant_id got %0d required 0", grant_id); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        rq[1].push_back({1'b1, 8'h72});
        rq[0].push_back({1'b1, 8'h63});
        exp_hdr(0);
        exp_q.push_back({2'd0, 8'h63});
        exp_hdr(1);
        exp_q.push_back({2'd1, 8'h72});
        wait_obs(exp_q.size(), ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_wait got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL rstmid_order got nothing required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL rstmid_order got %h required %h", o, e); end end
        end
        n_tests++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL rstmid_count got %0d required 2", pkt_count); end
    endtask

`ifdef UART_SCHED_HDR_EN
    task automatic test_header();
        bit ok;
        logic [9:0] e, o;
        apply_reset();
        rq[2].push_back({1'b1, 8'h5C});
        exp_q.push_back({2'd2, 8'hA2});
        exp_q.push_back({2'd2, 8'h5C});
        wait_obs(exp_q.size(), ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL hdr_wait got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL hdr_byte got nothing required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL hdr_byte got %h required %h", o, e); end end
        end
        n_tests++; if (ready_cnt[2] !== 1) begin n_fail++; $display("FAIL hdr_ready got %0d required 1", ready_cnt[2]); end
        n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL hdr_count got %0d required 1", pkt_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_force_release();
        test_stall();
        test_reset_mid();
`ifdef UART_SCHED_HDR_EN
        test_header();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
